param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter_if.sv | 63 ++++++
 rtl/param_updown_counter.sv | 111 +++++++++++
 tb/tb_param_updown_counter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// -----------------------------------------------------------------------------
// param_updown_counter_if
//   Bundles the control and status signals of param_updown_counter.
//   There is no valid/ready handshake: every control input is a level that is
//   sampled on each rising clk edge, and every status output is valid from one
//   clk edge to the next.
//
//   Optional feature macro: PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
//     adds ovf_clr (controller -> counter) and ovf_sticky (counter -> controller).
//
//   Signals
//     load       active-high synchronous load of load_val
//     load_val   value to load (clamped to limit by the counter)
//     en         active-high count enable
//     up_down    1 = count up, 0 = count down
//     limit      inclusive upper bound of the count range 0..limit
//     mode       0 = wrap at boundaries, 1 = saturate at boundaries
//     count      registered counter value
//     tc         registered one-cycle terminal-count pulse
//     at_zero    combinational, count == 0
//     at_limit   combinational, count >= limit
//   Modports
//     master     drives the controls, observes the status (testbench / parent)
//     slave      the counter itself
// -----------------------------------------------------------------------------
interface param_updown_counter_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_zero;
  logic             at_limit;
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
  logic             ovf_clr;
  logic             ovf_sticky;

  modport master (
    output load, load_val, en, up_down, limit, mode, ovf_clr,
    input  count, tc, at_zero, at_limit, ovf_sticky
  );

  modport slave (
    input  load, load_val, en, up_down, limit, mode, ovf_clr,
    output count, tc, at_zero, at_limit, ovf_sticky
  );
`else
  modport master (
    output load, load_val, en, up_down, limit, mode,
    input  count, tc, at_zero, at_limit
  );

  modport slave (
    input  load, load_val, en, up_down, limit, mode,
    output count, tc, at_zero, at_limit
  );
`endif
endinterface

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//   Up/down counter over the range 0..limit with selectable wrap or saturate
//   behaviour at the boundaries and a registered terminal-count pulse.
//
//   Parameters
//     WIDTH      counter width in bits (2..32)
//     RESET_VAL  count value after reset (clamped to limit)
//   Ports
//     clk        rising-edge clock
//     reset      synchronous active-high reset
//     bus        param_updown_counter_if.slave (controls in, count/status out)
//
//   Optional feature macro: PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
//     When defined, bus.ovf_sticky records any boundary event until bus.ovf_clr
//     is seen at an edge; a boundary on the same edge as ovf_clr keeps it set.
//
//   Edge priority: reset, then load, then en. No FSM; the only state is the
//   count register, the tc register and (optionally) the sticky flag.
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int WIDTH     = 16,
  parameter int RESET_VAL = 0
) (
  input logic                     clk,
  input logic                     reset,
  param_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             boundary;   // an enabled step hit an edge of 0..limit
  logic [WIDTH-1:0] reset_count;

  // The reset value is clamped against the live limit so count never starts
  // outside the legal range.
  always_comb begin
    reset_count = (RESET_V > bus.limit) ? bus.limit : RESET_V;
  end

  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    boundary = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (count_q >= bus.limit) begin
          boundary = 1'b1;
          tc_d     = 1'b1;
          count_d  = bus.mode ? bus.limit : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q > bus.limit) begin
          // limit was lowered below the current count: re-enter the range
          // at its top without treating it as a boundary event.
          count_d = bus.limit;
        end else if (count_q == '0) begin
          boundary = 1'b1;
          tc_d     = 1'b1;
          count_d  = bus.mode ? '0 : bus.limit;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= reset_count;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.at_zero  = (count_q == '0);
  assign bus.at_limit = (count_q >= bus.limit);

`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
  logic ovf_q;

  // Set has priority over clear so an event coinciding with ovf_clr is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (boundary) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf_sticky = ovf_q;
`else
  logic unused_boundary;
  assign unused_boundary = boundary;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//   Directed-vector bench for param_updown_counter (WIDTH=16, RESET_VAL=3).
//   Inputs change #1 after a rising edge; outputs are checked #1 after the
//   next rising edge, i.e. once the registered values have settled.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  localparam int WIDTH     = 16;
  localparam int RESET_VAL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  param_updown_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    bus.ovf_clr  = 1'b0;
`endif
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    set_idle();
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic check_ct(input string tag, input logic [WIDTH-1:0] c, input logic t);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".tc"},    32'(bus.tc),    32'(t));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    set_idle();
    bus.up_down = 1'b1;
    bus.limit   = 16'd9;
    bus.mode    = 1'b0;

    // Reset value clamped against limit
    step();
    check_ct("rst", 16'd3, 1'b0);
    check("rst.at_zero",  32'(bus.at_zero),  32'd0);
    check("rst.at_limit", 32'(bus.at_limit), 32'd0);
    bus.limit = 16'd2;
    step();
    check_ct("rst_clamp", 16'd2, 1'b0);
    check("rst_clamp.at_limit", 32'(bus.at_limit), 32'd1);
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    check("rst.ovf", 32'(bus.ovf_sticky), 32'd0);
`endif
    reset     = 1'b0;
    bus.limit = 16'd9;

    // Wrap up through limit 9
    do_load(16'd7);
    check_ct("ld7", 16'd7, 1'b0);
    bus.en = 1'b1; bus.up_down = 1'b1;
    step(); check_ct("up8", 16'd8, 1'b0);
    step(); check_ct("up9", 16'd9, 1'b0);
    check("up9.at_limit", 32'(bus.at_limit), 32'd1);
    step(); check_ct("wrap0", 16'd0, 1'b1);
    check("wrap0.at_zero", 32'(bus.at_zero), 32'd1);
    bus.en = 1'b0;
    step(); check_ct("hold", 16'd0, 1'b0);

    // Saturate down from 1
    bus.mode = 1'b1;
    do_load(16'd1);
    check_ct("ld1", 16'd1, 1'b0);
    bus.en = 1'b1; bus.up_down = 1'b0;
    step(); check_ct("sdn0", 16'd0, 1'b0);
    step(); check_ct("sdn1", 16'd0, 1'b1);
    step(); check_ct("sdn2", 16'd0, 1'b1);
    bus.en = 1'b0;
    step(); check_ct("sdn_off", 16'd0, 1'b0);

    // Full-range limit
    bus.limit = 16'hFFFF; bus.mode = 1'b0;
    do_load(16'hFFFF);
    bus.en = 1'b1; bus.up_down = 1'b1;
    step(); check_ct("full_wrap", 16'h0000, 1'b1);
    bus.mode = 1'b1;
    do_load(16'hFFFF);
    bus.en = 1'b1; bus.up_down = 1'b1;
    step(); check_ct("full_sat", 16'hFFFF, 1'b1);

    // Load clamp and re-entry after limit decrease
    bus.limit = 16'd9; bus.mode = 1'b0;
    do_load(16'd20);
    check_ct("ld_clamp", 16'd9, 1'b0);
    bus.limit = 16'd5;
    #1;
    check("reentry.at_limit", 32'(bus.at_limit), 32'd1);
    bus.en = 1'b1; bus.up_down = 1'b0;
    step(); check_ct("reentry", 16'd5, 1'b0);
    step(); check_ct("dn4", 16'd4, 1'b0);
    do_load(16'd0);
    bus.en = 1'b1; bus.up_down = 1'b0;
    step(); check_ct("wrap_dn", 16'd5, 1'b1);

    // limit == 0: both directions are boundaries
    bus.limit = 16'd0;
    do_load(16'd3);
    check_ct("l0_ld", 16'd0, 1'b0);
    bus.en = 1'b1; bus.up_down = 1'b1;
    step(); check_ct("l0_up", 16'd0, 1'b1);
    bus.up_down = 1'b0;
    step(); check_ct("l0_dn", 16'd0, 1'b1);

    // Reset overrides load and en, then counting resumes
    bus.limit = 16'd9; bus.up_down = 1'b1;
    reset = 1'b1; bus.load = 1'b1; bus.load_val = 16'd7; bus.en = 1'b1;
    step(); check_ct("rst_ovr", 16'd3, 1'b0);
`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    check("rst_ovr.ovf", 32'(bus.ovf_sticky), 32'd0);
`endif
    reset = 1'b0; bus.load = 1'b0;
    step(); check_ct("resume", 16'd4, 1'b0);

    // Load wins over en
    bus.load = 1'b1; bus.load_val = 16'd2; bus.en = 1'b1;
    step(); check_ct("ld_over_en", 16'd2, 1'b0);
    set_idle();

`ifdef PARAM_UPDOWN_COUNTER_OVF_STICKY_EN
    // Sticky overflow flag
    check("ovf.idle", 32'(bus.ovf_sticky), 32'd0);
    bus.mode = 1'b0; bus.up_down = 1'b1;
    do_load(16'd9);
    bus.en = 1'b1;
    step(); check_ct("ovf_wrap", 16'd0, 1'b1);
    check("ovf.set", 32'(bus.ovf_sticky), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("ovf.keep.count", 32'(bus.count), 32'(i));
      check("ovf.keep", 32'(bus.ovf_sticky), 32'd1);
    end
    bus.en = 1'b0; bus.ovf_clr = 1'b1;
    step(); check("ovf.clr", 32'(bus.ovf_sticky), 32'd0);
    do_load(16'd9);
    check("ovf.after_ld", 32'(bus.ovf_sticky), 32'd0);
    bus.en = 1'b1; bus.ovf_clr = 1'b1;
    step(); check_ct("ovf_setclr", 16'd0, 1'b1);
    check("ovf.set_wins", 32'(bus.ovf_sticky), 32'd1);
    set_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
